// File: rtl/spi_reg_loader.sv
// ============================================================================
//  Module   : spi_reg_loader
//  Purpose  : Parses byte frames from the SPI receiver (command byte followed
//             by data bytes) and writes into / reads back from an on-chip
//             bank of 8-bit configuration registers.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    iclk        in   internal clock, rising edge
//    rst         in   asynchronous active-high reset
//    byte_in     in   [7:0] received byte
//    byte_valid  in   one-cycle strobe qualifying byte_in
//    frame_end   in   one-cycle strobe, SPI frame finished
//    regs_out    out  [NUM_REGS*8-1:0] flattened register bank (reg k at 8k)
//    wr_strobe   out  one-cycle pulse after each register write
//    wr_addr     out  [AW-1:0] address of the last write
//    rd_data     out  [7:0] readback byte, held between pulses
//    rd_valid    out  one-cycle pulse qualifying rd_data
//    cmd_err     out  one-cycle pulse, command address out of range
//    busy        out  frame in progress (FSM not IDLE)
// ============================================================================
`default_nettype none

module spi_reg_loader #(
  parameter int NUM_REGS = 16,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                  iclk,
  input  logic                  rst,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  input  logic                  frame_end,
  output logic [NUM_REGS*8-1:0] regs_out,
  output logic                  wr_strobe,
  output logic [AW-1:0]         wr_addr,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic                  cmd_err,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WRITE   = 2'd1;
  localparam logic [1:0] S_READ    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  logic [1:0]    r_state;
  logic [AW-1:0] r_ptr;
  logic [7:0]    r_regs [NUM_REGS];
  logic          r_wr_strobe;
  logic [AW-1:0] r_wr_addr;
  logic [7:0]    r_rd_data;
  logic          r_rd_valid;
  logic          r_cmd_err;
  logic          r_busy;

  logic [1:0]    w_next_state;
  logic [6:0]    w_cmd_addr;
  logic          w_addr_bad;
  logic [AW-1:0] w_ptr_inc;

  assign w_cmd_addr = byte_in[6:0];
  // Compare at 8 bits so NUM_REGS=128 does not truncate to zero.
  assign w_addr_bad = ({1'b0, w_cmd_addr} >= 8'(NUM_REGS));
  // Explicit wrap: NUM_REGS need not be a power of two.
  assign w_ptr_inc  = (r_ptr == AW'(NUM_REGS - 1)) ? '0 : r_ptr + AW'(1);

  always_comb begin
    w_next_state = r_state;
    if (byte_valid && (r_state == S_IDLE)) begin
      if (w_addr_bad)      w_next_state = S_DISCARD;
      else if (byte_in[7]) w_next_state = S_WRITE;
      else                 w_next_state = S_READ;
    end
    // frame_end overrides: the byte in the same cycle is still processed.
    if (frame_end) w_next_state = S_IDLE;
  end

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_rd_data   <= 8'h00;
      r_rd_valid  <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_busy      <= (w_next_state != S_IDLE);
      r_wr_strobe <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_cmd_err   <= 1'b0;
      if (byte_valid) begin
        case (r_state)
          S_IDLE: begin
            if (w_addr_bad) begin
              r_cmd_err <= 1'b1;
            end else begin
              r_ptr <= w_cmd_addr[AW-1:0];
              if (!byte_in[7]) begin
                r_rd_data  <= r_regs[w_cmd_addr[AW-1:0]];
                r_rd_valid <= 1'b1;
              end
            end
          end
          S_WRITE: begin
            r_wr_strobe <= 1'b1;
            r_wr_addr   <= r_ptr;
            r_ptr       <= w_ptr_inc;
          end
          S_READ: begin
            // Dummy byte: advance first, then return the new location.
            r_ptr      <= w_ptr_inc;
            r_rd_data  <= r_regs[w_ptr_inc];
            r_rd_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= 8'h00;
    end else if (byte_valid && (r_state == S_WRITE)) begin
      r_regs[r_ptr] <= byte_in;
    end
  end

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
      assign regs_out[8*g +: 8] = r_regs[g];
    end
  endgenerate

  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign cmd_err   = r_cmd_err;
  assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_loader.sv
// ============================================================================
//  Module   : tb_spi_reg_loader
//  Purpose  : Directed frames with hand-computed expectations. Expected
//             write/read/error events go into queues; a negedge monitor pops
//             and compares whenever the DUT pulses an output.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_reg_loader;

  localparam int NUM_REGS = 16;
  localparam int AW       = 4;

  logic                  iclk = 1'b0;
  logic                  rst  = 1'b0;
  logic [7:0]            byte_in = 8'h00;
  logic                  byte_valid = 1'b0;
  logic                  frame_end = 1'b0;
  logic [NUM_REGS*8-1:0] regs_out;
  logic                  wr_strobe;
  logic [AW-1:0]         wr_addr;
  logic [7:0]            rd_data;
  logic                  rd_valid;
  logic                  cmd_err;
  logic                  busy;

  spi_reg_loader #(.NUM_REGS(NUM_REGS)) dut (
    .iclk       (iclk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .frame_end  (frame_end),
    .regs_out   (regs_out),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .cmd_err    (cmd_err),
    .busy       (busy)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    int         addr;
    logic [7:0] data;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] rq[$];
  int         err_pending = 0;
  logic [7:0] exp_regs [NUM_REGS];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected events, pushed by the stimulus with hand-computed values.
  task automatic exp_wr(input int a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    wq.push_back(e);
    exp_regs[a] = d;
  endtask

  task automatic exp_rd(input logic [7:0] d);
    rq.push_back(d);
  endtask

  task automatic check_bank(input string name);
    for (int k = 0; k < NUM_REGS; k++)
      check($sformatf("%s reg%0d", name, k), 32'(regs_out[8*k +: 8]), 32'(exp_regs[k]));
  endtask

  // Stimulus is applied 1 time unit after a rising edge; each call occupies
  // exactly one cycle so successive calls are back-to-back.
  task automatic drive(input logic [7:0] b, input logic fe);
    byte_in    = b;
    byte_valid = 1'b1;
    frame_end  = fe;
    @(posedge iclk); #1;
    byte_valid = 1'b0;
    frame_end  = 1'b0;
  endtask

  task automatic end_frame();
    frame_end = 1'b1;
    @(posedge iclk); #1;
    frame_end = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge iclk); #1; end
  endtask

  // Monitor: compares every DUT pulse against the head of its queue.
  always @(negedge iclk) begin
    if (!rst) begin
      if (wr_strobe) begin
        if (wq.size() == 0) begin
          check("unexpected wr_strobe", 32'd1, 32'd0);
        end else begin
          wr_t e;
          e = wq.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e.addr));
          check("wr_data", 32'(regs_out[8*e.addr +: 8]), 32'(e.data));
        end
      end
      if (rd_valid) begin
        if (rq.size() == 0) check("unexpected rd_valid", 32'd1, 32'd0);
        else                check("rd_data", 32'(rd_data), 32'(rq.pop_front()));
      end
      if (cmd_err) begin
        if (err_pending == 0) check("unexpected cmd_err", 32'd1, 32'd0);
        else begin
          err_pending--;
          check("cmd_err", 32'(cmd_err), 32'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = 8'h00;

    // Reset
    rst = 1'b1;
    idle(3);
    check("reset regs_out", 32'(regs_out == '0), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset wr_strobe", 32'(wr_strobe), 32'd0);
    check("reset rd_valid", 32'(rd_valid), 32'd0);
    check("reset cmd_err", 32'(cmd_err), 32'd0);
    check("reset rd_data", 32'(rd_data), 32'd0);
    check("reset wr_addr", 32'(wr_addr), 32'd0);
    rst = 1'b0;
    idle(2);

    // Write burst: 0x83 AA BB -> reg3=AA, reg4=BB
    exp_wr(3, 8'hAA);
    exp_wr(4, 8'hBB);
    drive(8'h83, 1'b0);
    check("busy after write cmd", 32'(busy), 32'd1);
    drive(8'hAA, 1'b0);
    drive(8'hBB, 1'b0);
    end_frame();
    check("busy after frame_end", 32'(busy), 32'd0);
    idle(1);
    check_bank("write burst");

    // Wrap: 0x8F 11 22 -> reg15=11, reg0=22
    exp_wr(15, 8'h11);
    exp_wr(0, 8'h22);
    drive(8'h8F, 1'b0);
    drive(8'h11, 1'b0);
    drive(8'h22, 1'b0);
    end_frame();
    idle(1);
    check_bank("wrap");

    // Read: 0x03 00 00 -> AA, BB, 00
    exp_rd(8'hAA);
    exp_rd(8'hBB);
    exp_rd(8'h00);
    drive(8'h03, 1'b0);
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b0);
    end_frame();
    idle(1);
    check("rd_data held", 32'(rd_data), 32'h00);
    check_bank("after read");

    // Out-of-range command: 0x90 55 -> one cmd_err, no write
    err_pending++;
    drive(8'h90, 1'b0);
    drive(8'h55, 1'b0);
    check("busy in discard", 32'(busy), 32'd1);
    end_frame();
    idle(1);
    check_bank("discard");
    exp_wr(1, 8'h77);
    drive(8'h81, 1'b0);
    drive(8'h77, 1'b0);
    end_frame();
    idle(1);
    check_bank("after error");

    // Read command with frame_end in the same cycle -> one rd_valid (reg4)
    exp_rd(8'hBB);
    drive(8'h04, 1'b1);
    check("busy after cmd+frame_end", 32'(busy), 32'd0);
    idle(2);

    // Reset mid-frame: the next byte is a command again
    exp_wr(5, 8'h12);
    drive(8'h85, 1'b0);
    drive(8'h12, 1'b0);
    idle(1);
    rst = 1'b1;
    for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = 8'h00;
    idle(1);
    rst = 1'b0;
    check("busy after mid-frame reset", 32'(busy), 32'd0);
    check_bank("mid-frame reset");
    err_pending++;               // 0x34 is a read of address 52: out of range
    drive(8'h34, 1'b0);
    drive(8'h56, 1'b0);
    end_frame();
    exp_wr(6, 8'h99);
    drive(8'h86, 1'b0);
    drive(8'h99, 1'b0);
    end_frame();
    idle(3);
    check_bank("final");

    // Every expected event must have been observed
    check("pending writes", 32'(wq.size()), 32'd0);
    check("pending reads", 32'(rq.size()), 32'd0);
    check("pending errors", 32'(err_pending), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
